// File: rtl/regfile_write_arbiter.sv
// Arbitrates the ALU and load writeback paths onto the single register-file write port.
// Each source has a one-entry buffer; grants are round-robin, with MEM first on a same-index collision.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [4:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       wr_sel,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic              alu_full_q, alu_full_d;
  logic [AW-1:0]     alu_addr_q, alu_addr_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              mem_full_q, mem_full_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  src_e              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   wr_sel_q, wr_sel_d;
  logic [CNT_W-1:0]  conflict_q, conflict_d;

  logic              gnt_alu, gnt_mem, gnt_any, both_full;
  logic [AW-1:0]     gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Grant depends only on buffered state, never on incoming valids.
  always_comb begin
    gnt_alu   = 1'b0;
    gnt_mem   = 1'b0;
    both_full = alu_full_q & mem_full_q;
    if (both_full) begin
      // Same index: the older load lands first so the younger ALU value wins.
      if (alu_addr_q == mem_addr_q) begin
        gnt_mem = 1'b1;
      end else if (last_q == SRC_MEM) begin
        gnt_alu = 1'b1;
      end else begin
        gnt_mem = 1'b1;
      end
    end else if (alu_full_q) begin
      gnt_alu = 1'b1;
    end else if (mem_full_q) begin
      gnt_mem = 1'b1;
    end
    gnt_any  = gnt_alu | gnt_mem;
    gnt_addr = gnt_mem ? mem_addr_q : alu_addr_q;
    gnt_data = gnt_mem ? mem_data_q : alu_data_q;
  end

  assign alu_ready = ~alu_full_q | gnt_alu;
  assign mem_ready = ~mem_full_q | gnt_mem;

  // Next-state for buffers, pointer, output command and conflict counter.
  always_comb begin
    alu_full_d = alu_full_q;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    mem_full_d = mem_full_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    last_d     = last_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_sel_d   = '0;
    conflict_d = conflict_q;

    if (alu_valid && alu_ready) begin
      alu_full_d = 1'b1;
      alu_addr_d = alu_addr;
      alu_data_d = alu_data;
    end else if (gnt_alu) begin
      alu_full_d = 1'b0;
    end

    if (mem_valid && mem_ready) begin
      mem_full_d = 1'b1;
      mem_addr_d = mem_addr;
      mem_data_d = mem_data;
    end else if (gnt_mem) begin
      mem_full_d = 1'b0;
    end

    if (gnt_any) begin
      last_d = gnt_mem ? SRC_MEM : SRC_ALU;
      if (gnt_addr != AW'(ZERO_REG)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = gnt_addr;
        wr_data_d = gnt_data;
        wr_sel_d  = NREG'(1) << gnt_addr;
      end
    end

    if (both_full && (conflict_q != {CNT_W{1'b1}})) begin
      conflict_d = conflict_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_full_q <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      mem_full_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      last_q     <= SRC_MEM;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_sel_q   <= '0;
      conflict_q <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_addr_q <= alu_addr_d;
      alu_data_q <= alu_data_d;
      mem_full_q <= mem_full_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      last_q     <= last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_sel_q   <= wr_sel_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_sel       = wr_sel_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, scoreboard of expected writes, corner sequences.
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              reset_n;
  logic              alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]        alu_addr, mem_addr, wr_addr;
  logic [DATA_W-1:0] alu_data, mem_data, wr_data;
  logic              wr_en;
  logic [31:0]       wr_sel;
  logic [CNT_W-1:0]  conflict_cnt;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(wr_sel),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    bit                is_mem;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
    bit                exp_en;
    logic [4:0]        exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [31:0]       exp_sel;
  } vec_t;

  wr_t               exp_q[$];
  int                total = 0;
  int                bad   = 0;
  logic [DATA_W-1:0] row7;
  logic [31:0]       mon_dec;
  wr_t               mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the next expected write in order.
  always @(negedge clk) begin
    if (reset_n) begin
      mon_dec = wr_en ? (32'd1 << wr_addr) : 32'd0;
      check("sel_invariant", 64'(wr_sel), 64'(mon_dec));
      check("sel_zero_reg", 64'(wr_sel[31]), 64'd0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%h want none at %0t", wr_addr, wr_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_addr", 64'(wr_addr), 64'(mon_e.addr));
          check("sb_data", 64'(wr_data), 64'(mon_e.data));
          if (wr_addr == 5'd7) row7 = wr_data;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst_en",   64'(wr_en),        64'd0);
    check("rst_addr", 64'(wr_addr),      64'd0);
    check("rst_data", 64'(wr_data),      64'd0);
    check("rst_sel",  64'(wr_sel),       64'd0);
    check("rst_cnt",  64'(conflict_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic apply(input bit av, input logic [4:0] aa, input logic [DATA_W-1:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [DATA_W-1:0] md);
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    if (av) check("alu_ready_accept", 64'(alu_ready), 64'd1);
    if (mv) check("mem_ready_accept", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  // Two sources streaming back to back; each holds valid until its handshake.
  task automatic run_streams(input int n, input int abase, input int mbase);
    int  ai, mi, guard;
    bit  ra, rm;
    ai = 0; mi = 0; guard = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({5'(abase + i), 64'hA000_0000_0000_0000 | 64'(i)});
      exp_q.push_back({5'(mbase + i), 64'hB000_0000_0000_0000 | 64'(i)});
    end
    while ((ai < n || mi < n) && guard < 4 * n + 10) begin
      @(negedge clk);
      alu_valid = (ai < n);
      alu_addr  = 5'(abase + ai);
      alu_data  = 64'hA000_0000_0000_0000 | 64'(ai);
      mem_valid = (mi < n);
      mem_addr  = 5'(mbase + mi);
      mem_data  = 64'hB000_0000_0000_0000 | 64'(mi);
      #1;
      ra = alu_ready;
      rm = mem_ready;
      @(posedge clk);
      if (alu_valid && ra) ai++;
      if (mem_valid && rm) mi++;
      guard++;
    end
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    if (ai < n || mi < n) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: got alu=%0d mem=%0d want %0d each", ai, mi, n);
    end
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 5'd5,  64'hA5,                  1'b1, 5'd5,  64'hA5,                  32'h0000_0020};
    vecs[1] = '{1'b1, 5'd0,  64'h1234,                1'b1, 5'd0,  64'h1234,                32'h0000_0001};
    vecs[2] = '{1'b0, 5'd30, 64'hDEAD_BEEF_0000_0001, 1'b1, 5'd30, 64'hDEAD_BEEF_0000_0001, 32'h4000_0000};
    vecs[3] = '{1'b1, 5'd31, 64'hFF,                  1'b0, 5'd30, 64'hDEAD_BEEF_0000_0001, 32'h0000_0000};
    vecs[4] = '{1'b0, 5'd31, 64'h77,                  1'b0, 5'd30, 64'hDEAD_BEEF_0000_0001, 32'h0000_0000};
    vecs[5] = '{1'b1, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0002_0000};

    clk = 1'b0; reset_n = 1'b0; row7 = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    do_reset();

    // Single requests: two-edge latency, one-cycle strobe, zero-register drop.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_en) exp_q.push_back({vecs[v].exp_addr, vecs[v].exp_data});
      apply(!vecs[v].is_mem, vecs[v].addr, vecs[v].data, vecs[v].is_mem, vecs[v].addr, vecs[v].data);
      @(negedge clk);
      check("vec_en_early", 64'(wr_en), 64'd0);
      @(negedge clk);
      check("vec_en",   64'(wr_en),   64'(vecs[v].exp_en));
      check("vec_addr", 64'(wr_addr), 64'(vecs[v].exp_addr));
      check("vec_data", 64'(wr_data), vecs[v].exp_data);
      check("vec_sel",  64'(wr_sel),  64'(vecs[v].exp_sel));
      check("vec_ready", 64'(vecs[v].is_mem ? mem_ready : alu_ready), 64'd1);
      @(negedge clk);
      check("vec_en_late", 64'(wr_en), 64'd0);
    end
    check("cnt_no_conflict", 64'(conflict_cnt), 64'd0);

    // Same-index collision with last grant ALU: MEM first, ALU value last.
    exp_q.push_back({5'd2, 64'h22});
    apply(1'b1, 5'd2, 64'h22, 1'b0, 5'd0, 64'h0);
    repeat (3) @(negedge clk);
    exp_q.push_back({5'd7, 64'h2});
    exp_q.push_back({5'd7, 64'h1});
    apply(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2);
    repeat (4) @(negedge clk);
    check("row7_final", 64'(row7), 64'h1);
    check("cnt_after_collision", 64'(conflict_cnt), 64'd1);

    // Same-index collision with last grant MEM: pointer is overridden.
    exp_q.push_back({5'd3, 64'h33});
    apply(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h33);
    repeat (3) @(negedge clk);
    exp_q.push_back({5'd12, 64'hB});
    exp_q.push_back({5'd12, 64'hA});
    apply(1'b1, 5'd12, 64'hA, 1'b1, 5'd12, 64'hB);
    repeat (4) @(negedge clk);
    check("sb_drained_collision", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with both buffers full drops the pending entries.
    do_reset();
    exp_q.push_back({5'd3, 64'h3});
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'h3;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 64'h4;
    @(negedge clk);
    alu_addr = 5'd5; alu_data = 64'h5;
    mem_valid = 1'b0;
    @(negedge clk);
    alu_valid = 1'b0;
    check("pre_rst_en",  64'(wr_en),        64'd1);
    check("pre_rst_cnt", 64'(conflict_cnt), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_en",   64'(wr_en),        64'd0);
    check("async_addr", 64'(wr_addr),      64'd0);
    check("async_data", 64'(wr_data),      64'd0);
    check("async_sel",  64'(wr_sel),       64'd0);
    check("async_cnt",  64'(conflict_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("sb_drained_reset", 64'(exp_q.size()), 64'd0);

    // Back-to-back streams alternate ALU, MEM, ALU, ...
    do_reset();
    run_streams(8, 1, 9);
    check("sb_drained_streams", 64'(exp_q.size()), 64'd0);
    check("cnt_streams", 64'(conflict_cnt), 64'd15);

    // Long contention saturates the counter.
    do_reset();
    run_streams(12, 1, 13);
    check("cnt_saturated", 64'(conflict_cnt), 64'd15);
    repeat (5) @(negedge clk);
    check("cnt_holds", 64'(conflict_cnt), 64'd15);
    check("sb_drained_final", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
